// File: rtl/insn_sequencer_if.sv
// Instruction fetch bus: the sequencer is the only master, instruction memory is the slave.
interface insn_sequencer_if;
    logic [63:0] iadr;
    logic        icyc;
    logic        istb;
    logic        iack;
    logic [31:0] idat;

    modport master (output iadr, output icyc, output istb, input iack, input idat);
    modport slave  (input iadr, input icyc, input istb, output iack, output idat);
endinterface

// File: rtl/insn_sequencer.sv
// Polaris instruction sequencer: fetches into IR, steps the micro-cycle counter for the
// combinational decoders, retires instructions by advancing or loading the PC, and raises traps.
module insn_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'hFFFF_FFFF_FFFF_FF00,
    parameter logic [63:0] TRAP_VEC  = 64'hFFFF_FFFF_FFFF_FE00,
    parameter int unsigned MAX_STEPS = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    insn_sequencer_if.master ibus,
    output logic [31:0]      ir_o,
    output logic [2:0]       cstate_o,
    input  logic [2:0]       nstate_i,
    input  logic             defined_i,
    input  logic             pc_ld_i,
    input  logic [63:0]      pc_dat_i,
    output logic [63:0]      pc_o,
    output logic             exec_o,
    output logic             trap_o,
    output logic [1:0]       cause_o,
    output logic [63:0]      epc_o
);
    localparam int unsigned       STEP_W    = $clog2(MAX_STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);
    localparam logic [STEP_W-1:0] ONE_STEP  = STEP_W'(1);
    localparam logic [31:0]       NOP_INSN  = 32'h0000_0013;
    localparam logic [1:0]        CAUSE_MISALIGN = 2'd0;
    localparam logic [1:0]        CAUSE_UNDEF    = 2'd1;
    localparam logic [1:0]        CAUSE_WDOG     = 2'd2;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [63:0]       pc_r, pc_s;
    logic [63:0]       epc_r, epc_s;
    logic [31:0]       ir_r, ir_s;
    logic [2:0]        cstate_r, cstate_s;
    logic [STEP_W-1:0] steps_r, steps_s;
    logic [1:0]        cause_r, cause_s;
    logic              icyc_r, exec_r, trap_r;

    // Next-state and datapath update for the fetch/execute/trap sequence
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        epc_s    = epc_r;
        ir_s     = ir_r;
        cstate_s = cstate_r;
        steps_s  = steps_r;
        cause_s  = cause_r;
        case (state_r)
            ST_FETCH: begin
                if (ibus.iack) begin
                    ir_s     = ibus.idat;
                    cstate_s = 3'd0;
                    steps_s  = {STEP_W{1'b0}};
                    state_s  = ST_EXEC;
                end else begin
                    state_s  = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (!defined_i) begin
                    cause_s = CAUSE_UNDEF;
                    epc_s   = pc_r;
                    state_s = ST_TRAP;
                end else if (nstate_i == cstate_r) begin
                    // A misaligned jump target traps with the PC left on the faulting insn
                    if (pc_ld_i && (pc_dat_i[1:0] != 2'b00)) begin
                        cause_s = CAUSE_MISALIGN;
                        epc_s   = pc_r;
                        state_s = ST_TRAP;
                    end else begin
                        pc_s    = pc_ld_i ? pc_dat_i : (pc_r + 64'd4);
                        state_s = ST_FETCH;
                    end
                end else if (steps_r == LAST_STEP) begin
                    cause_s = CAUSE_WDOG;
                    epc_s   = pc_r;
                    state_s = ST_TRAP;
                end else begin
                    cstate_s = nstate_i;
                    steps_s  = steps_r + ONE_STEP;
                end
            end
            ST_TRAP: begin
                pc_s     = TRAP_VEC;
                cstate_s = 3'd0;
                state_s  = ST_FETCH;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // State register; bus and status flags are registered from the next state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= ST_FETCH;
            pc_r     <= RESET_PC;
            epc_r    <= 64'd0;
            ir_r     <= NOP_INSN;
            cstate_r <= 3'd0;
            steps_r  <= {STEP_W{1'b0}};
            cause_r  <= 2'd0;
            icyc_r   <= 1'b1;
            exec_r   <= 1'b0;
            trap_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            epc_r    <= epc_s;
            ir_r     <= ir_s;
            cstate_r <= cstate_s;
            steps_r  <= steps_s;
            cause_r  <= cause_s;
            icyc_r   <= (state_s == ST_FETCH);
            exec_r   <= (state_s == ST_EXEC);
            trap_r   <= (state_s == ST_TRAP);
        end
    end

    assign ibus.iadr = pc_r;
    assign ibus.icyc = icyc_r;
    assign ibus.istb = icyc_r;
    assign ir_o      = ir_r;
    assign cstate_o  = cstate_r;
    assign pc_o      = pc_r;
    assign exec_o    = exec_r;
    assign trap_o    = trap_r;
    assign cause_o   = cause_r;
    assign epc_o     = epc_r;
endmodule
